load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator-side master for the byte-addressable unified memory. It turns CPU load/store requests into memory port cycles on addr/data/read_en/write_en.
- Supports byte, halfword and word accesses, little-endian.
- Sub-word stores use read-modify-write, because the memory write port is full-word.
- Returns sign- or zero-extended load data with a one-cycle response pulse. Sits between the execute stage and the memory.

Parameters:
- AWIDTH, 32, address width (memory and request side)
- DWIDTH, 32, data width; fixed at 32 for lane logic
- BASE_ADDR, 32'h01000000, lowest legal address; requests below it are errors

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  unit idle, can accept
- req_addr_i  in  AWIDTH  byte address
- req_wdata_i  in  DWIDTH  store data, right-justified
- req_we_i  in  1  1=store, 0=load
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned_i  in  1  zero-extend load (LBU/LHU)
- resp_valid_o  out  1  one-cycle completion pulse
- resp_rdata_o  out  DWIDTH  extended load data; 0 for stores/errors
- resp_err_o  out  1  misaligned/illegal/out-of-range, valid with resp_valid_o
- mem_addr_o  out  AWIDTH  word-aligned address (req_addr & ~3)
- mem_data_o  out  DWIDTH  write word
- mem_read_en_o  out  1  memory read strobe
- mem_write_en_o  out  1  memory write strobe (memory writes on rising edge)
- mem_data_i  in  DWIDTH  combinational read data from memory

Behaviour:
- Reset (rst=0, async):
  - FSM goes to IDLE; all request/data registers clear.
  - resp_valid_o=0, resp_err_o=0, resp_rdata_o=0.
  - mem_read_en_o=0, mem_write_en_o=0, mem_addr_o=0, mem_data_o=0.
  - req_ready_o=0 while rst=0, 1 from the first cycle after release.
- FSM states: IDLE, LOAD, RMW_RD, STORE, RESP.
- IDLE:
  - req_ready_o=1. Accept on the rising edge where req_valid_i&req_ready_o; latch addr/wdata/we/size/unsigned.
  - Error if size=11, half with addr[0]=1, word with addr[1:0]!=0, or addr<BASE_ADDR.
  - Next state: error -> RESP; else load -> LOAD; word store -> STORE; byte/half store -> RMW_RD.
- LOAD:
  - mem_read_en_o=1, mem_addr_o=aligned address.
  - Extract lane by addr[1:0] (byte) or addr[1] (half). Sign-extend unless unsigned. Register into resp_rdata -> RESP.
- RMW_RD:
  - mem_read_en_o=1.
  - Capture mem_data_i with the target byte/half lane replaced by req_wdata[7:0]/[15:0] -> STORE.
- STORE:
  - mem_write_en_o=1, mem_data_o = merged word (sub-word) or req_wdata (word) -> RESP.
- RESP:
  - resp_valid_o=1 for exactly one cycle, no backpressure. req_ready_o=0 -> IDLE.
  - resp_rdata_o is held until the next accepted request.
- Strobes: read_en and write_en are never both 1. Both are decoded from state only; no combinational path from req_* to mem_*.
- Latency (accept edge = E):
  - error: resp_valid_o high in cycle after E
  - load / word store: cycle after E+1
  - byte/half store: cycle after E+2
- Throughput: one request per 3 (load/word store) or 4 (sub-word store) cycles; req_ready_o low in all non-IDLE states.
- Reset mid-operation:
  - Abort immediately; write_en drops asynchronously. No memory write occurs unless the STORE-state rising edge has already happened. No response is issued.
- Errors never touch memory; resp_rdata_o=0.
- Address wrap: aligned address computed by masking only; no increment, no wrap logic.

Decomposition:
- Package lsu_pkg:
  - size_e (SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10)
  - lsu_state_e
  - function misaligned(addr, size)
- Sub-module lsu_lane_align, purely combinational:
  - extract path (word, offset, size, unsigned -> data)
  - merge path (old word, wdata, offset, size -> new word)
  - unit-testable standalone

Test Plan:
- Word load: memory word @0x01000004=0xDEADBEEF; load word 0x01000004 -> mem_read_en 1 cycle at addr 0x01000004; resp_rdata=0xDEADBEEF, err=0, resp two cycles after accept.
- Byte loads: same word; LB @0x01000007 -> 0xFFFFFFDE; LBU @0x01000007 -> 0x000000DE; LH @0x01000004 -> 0xFFFFBEEF; LHU @0x01000006 -> 0x0000DEAD.
- Byte store RMW: word 0x11223344 @0x01000008; SB 0xAA @0x01000009 -> read cycle, then write 0x1122AA44; resp_valid three cycles after accept; later word load returns 0x1122AA44.
- Errors: LW @0x01000002, SH @0x01000001, size=11, LW @0x00FFFFFC -> resp_err=1 next cycle, resp_rdata=0, no mem_read_en/mem_write_en pulse.
- Back-to-back: req_valid held high across SW then LW to same address -> second accepted only after RESP, returns stored value; req_ready low in between.
- Reset: assert rst low during the RMW_RD cycle of an SB -> no write strobe, outputs 0, memory word unchanged. After release, req_ready_o=1 and the next request completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
package lsu_pkg;

  // Access size encoding as presented on the request port; 2'b11 is illegal.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RMW_RD,
    ST_STORE,
    ST_RESP
  } lsu_state_e;

  // True when the low address bits do not suit the access size.
  // The illegal size code is folded in so callers get one error term.
  function automatic logic misaligned(input logic [1:0] offset, input logic [1:0] size);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = offset[0];
      SZ_WORD: misaligned = (offset != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane steering: extracts a sign/zero-extended byte or half
// from a memory word, and merges store data into an old word for RMW.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] ext_word_i,
  output logic [31:0] ext_data_o,
  input  logic [31:0] old_word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [4:0]  lane_shift;
  logic [31:0] lane_mask;
  logic [31:0] lane_ins;

  assign lane_shift = {offset_i, 3'b000};

  // Select the addressed byte and half of the fetched word.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    byte_sel = ext_word_i[7:0];
    case (offset_i)
      2'd1:    byte_sel = ext_word_i[15:8];
      2'd2:    byte_sel = ext_word_i[23:16];
      2'd3:    byte_sel = ext_word_i[31:24];
      default: byte_sel = ext_word_i[7:0];
    endcase
    half_sel = offset_i[1] ? ext_word_i[31:16] : ext_word_i[15:0];
  end

  // Extend the selected lane to a full word.
  always_comb begin
    ext_data_o = ext_word_i;
    case (size_i)
      SZ_BYTE: ext_data_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: ext_data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
      default: ext_data_o = ext_word_i;
    endcase
  end

  // Replace the target lane of the old word with the store data.
  always_comb begin
    lane_mask = 32'hFFFF_FFFF;
    lane_ins  = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        lane_mask = 32'h0000_00FF << lane_shift;
        lane_ins  = {24'h0, wdata_i[7:0]} << lane_shift;
      end
      SZ_HALF: begin
        lane_mask = 32'h0000_FFFF << lane_shift;
        lane_ins  = {16'h0, wdata_i[15:0]} << lane_shift;
      end
      default: begin
        lane_mask = 32'hFFFF_FFFF;
        lane_ins  = wdata_i;
      end
    endcase
    merged_o = (old_word_i & ~lane_mask) | (lane_ins & lane_mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns CPU load/store requests into single-word memory
// cycles, doing read-modify-write for byte and half stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int                AWIDTH    = 32,
  parameter int                DWIDTH    = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR = 32'h0100_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [AWIDTH-1:0] req_addr_i,
  input  logic [DWIDTH-1:0] req_wdata_i,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  output logic              resp_valid_o,
  output logic [DWIDTH-1:0] resp_rdata_o,
  output logic              resp_err_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  input  logic [DWIDTH-1:0] mem_data_i
);

  lsu_state_e        state_q, state_d;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] wdata_q;   // store data, becomes the merged word after RMW_RD
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic              err_q;
  logic [DWIDTH-1:0] rdata_q;

  logic              accept;
  logic              req_err;
  logic [DWIDTH-1:0] ext_data;
  logic [DWIDTH-1:0] merged;

  // Ready is forced low while reset is held; the FSM already sits in IDLE.
  assign req_ready_o = rst & (state_q == ST_IDLE);
  assign accept      = req_valid_i & req_ready_o;
  assign req_err     = misaligned(req_addr_i[1:0], req_size_i) | (req_addr_i < BASE_ADDR);

  lsu_lane_align u_lane_align (
    .offset_i   (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .ext_word_i (mem_data_i),
    .ext_data_o (ext_data),
    .old_word_i (mem_data_i),
    .wdata_i    (wdata_q),
    .merged_o   (merged)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_err)                  state_d = ST_RESP;
          else if (!req_we_i)           state_d = ST_LOAD;
          else if (req_size_i == SZ_WORD) state_d = ST_STORE;
          else                          state_d = ST_RMW_RD;
        end
      end
      ST_LOAD:   state_d = ST_RESP;
      ST_RMW_RD: state_d = ST_STORE;
      ST_STORE:  state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Request latch, load-data capture and RMW merge capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            we_q    <= req_we_i;
            size_q  <= req_size_i;
            uns_q   <= req_unsigned_i;
            err_q   <= req_err;
            rdata_q <= '0;
          end
        end
        ST_LOAD:   rdata_q <= ext_data;
        ST_RMW_RD: wdata_q <= merged;
        default: ;
      endcase
    end
  end

  // Memory strobes and response are decoded from registered state only, so
  // reset drops them asynchronously and no req_* input reaches mem_*.
  assign mem_read_en_o  = (state_q == ST_LOAD) || (state_q == ST_RMW_RD);
  assign mem_write_en_o = (state_q == ST_STORE) && we_q;
  assign mem_addr_o     = {addr_q[AWIDTH-1:2], 2'b00};
  assign mem_data_o     = (state_q == ST_STORE) ? wdata_q : '0;
  assign resp_valid_o   = (state_q == ST_RESP);
  assign resp_err_o     = resp_valid_o & err_q;
  assign resp_rdata_o   = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a small word-memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        mem_read_en_o;
  logic        mem_write_en_o;
  logic [31:0] mem_data_i;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [0:15];
  int          rd_cnt;
  int          wr_cnt;
  int          both_cnt = 0;
  logic [31:0] rd_addr;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .req_we_i       (req_we_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .resp_valid_o   (resp_valid_o),
    .resp_rdata_o   (resp_rdata_o),
    .resp_err_o     (resp_err_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_read_en_o  (mem_read_en_o),
    .mem_write_en_o (mem_write_en_o),
    .mem_data_i     (mem_data_i)
  );

  // Memory model: combinational read, write on rising edge.
  assign mem_data_i = mem[mem_addr_o[5:2]];

  always @(posedge clk) begin
    if (mem_write_en_o) begin
      mem[mem_addr_o[5:2]] <= mem_data_o;
      wr_cnt = wr_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (mem_read_en_o) begin
      rd_cnt  = rd_cnt + 1;
      rd_addr = mem_addr_o;
    end
    if (mem_read_en_o && mem_write_en_o) both_cnt = both_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One request from idle to response, with latency, strobe and data checks.
  task automatic run_req(input string name, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    int cyc;
    int exp_lat;
    int exp_rd;
    int exp_wr;
    exp_lat = exp_err ? 1 : ((!we || size == 2'b10) ? 2 : 3);
    exp_rd  = (!exp_err && (!we || size != 2'b10)) ? 1 : 0;
    exp_wr  = (!exp_err && we) ? 1 : 0;
    @(negedge clk);
    n = 0;
    while (!req_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, " ready"}, {31'b0, req_ready_o}, 32'd1);
    rd_cnt         = 0;
    wr_cnt         = 0;
    req_valid_i    = 1'b1;
    req_we_i       = we;
    req_size_i     = size;
    req_unsigned_i = uns;
    req_addr_i     = addr;
    req_wdata_i    = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    cyc = 1;
    while (!resp_valid_o && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check({name, " latency"}, cyc, exp_lat);
    check({name, " rdata"}, resp_rdata_o, exp_rdata);
    check({name, " err"}, {31'b0, resp_err_o}, {31'b0, exp_err});
    check({name, " reads"}, rd_cnt, exp_rd);
    check({name, " writes"}, wr_cnt, exp_wr);
    if (exp_rd != 0) check({name, " rd addr"}, rd_addr, addr & 32'hFFFF_FFFC);
    @(negedge clk);
    check({name, " pulse/ready"}, {30'b0, resp_valid_o, req_ready_o}, 32'd1);
    check({name, " rdata held"}, resp_rdata_o, exp_rdata);
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [18];

  initial begin
    vecs[0]  = '{"lw",        1'b0, 2'b10, 1'b0, 32'h0100_0004, 32'h0,          32'hDEAD_BEEF, 1'b0};
    vecs[1]  = '{"lb7",       1'b0, 2'b00, 1'b0, 32'h0100_0007, 32'h0,          32'hFFFF_FFDE, 1'b0};
    vecs[2]  = '{"lbu7",      1'b0, 2'b00, 1'b1, 32'h0100_0007, 32'h0,          32'h0000_00DE, 1'b0};
    vecs[3]  = '{"lh4",       1'b0, 2'b01, 1'b0, 32'h0100_0004, 32'h0,          32'hFFFF_BEEF, 1'b0};
    vecs[4]  = '{"lhu6",      1'b0, 2'b01, 1'b1, 32'h0100_0006, 32'h0,          32'h0000_DEAD, 1'b0};
    vecs[5]  = '{"lb4",       1'b0, 2'b00, 1'b0, 32'h0100_0004, 32'h0,          32'hFFFF_FFEF, 1'b0};
    vecs[6]  = '{"lbu5",      1'b0, 2'b00, 1'b1, 32'h0100_0005, 32'h0,          32'h0000_00BE, 1'b0};
    vecs[7]  = '{"lh6",       1'b0, 2'b01, 1'b0, 32'h0100_0006, 32'h0,          32'hFFFF_DEAD, 1'b0};
    vecs[8]  = '{"sb9",       1'b1, 2'b00, 1'b0, 32'h0100_0009, 32'h0000_00AA, 32'h0,          1'b0};
    vecs[9]  = '{"lw after sb", 1'b0, 2'b10, 1'b0, 32'h0100_0008, 32'h0,        32'h1122_AA44, 1'b0};
    vecs[10] = '{"shA",       1'b1, 2'b01, 1'b0, 32'h0100_000A, 32'h5555_CAFE, 32'h0,          1'b0};
    vecs[11] = '{"lw after sh", 1'b0, 2'b10, 1'b0, 32'h0100_0008, 32'h0,        32'hCAFE_AA44, 1'b0};
    vecs[12] = '{"err lw mis", 1'b0, 2'b10, 1'b0, 32'h0100_0002, 32'h0,         32'h0,          1'b1};
    vecs[13] = '{"err sh mis", 1'b1, 2'b01, 1'b0, 32'h0100_0001, 32'h0000_1234, 32'h0,          1'b1};
    vecs[14] = '{"err size3", 1'b0, 2'b11, 1'b0, 32'h0100_0004, 32'h0,          32'h0,          1'b1};
    vecs[15] = '{"err range", 1'b0, 2'b10, 1'b0, 32'h00FF_FFFC, 32'h0,          32'h0,          1'b1};
    vecs[16] = '{"sw",        1'b1, 2'b10, 1'b0, 32'h0100_000C, 32'h1234_5678, 32'h0,          1'b0};
    vecs[17] = '{"lw after sw", 1'b0, 2'b10, 1'b0, 32'h0100_000C, 32'h0,        32'h1234_5678, 1'b0};

    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[1] = 32'hDEAD_BEEF;
    mem[2] = 32'h1122_3344;
    rd_cnt = 0;
    wr_cnt = 0;
    rd_addr = 32'h0;

    rst            = 1'b0;
    req_valid_i    = 1'b0;
    req_addr_i     = 32'h0;
    req_wdata_i    = 32'h0;
    req_we_i       = 1'b0;
    req_size_i     = 2'b00;
    req_unsigned_i = 1'b0;

    // Reset state.
    #1;
    check("reset strobes", {27'b0, req_ready_o, resp_valid_o, resp_err_o, mem_read_en_o, mem_write_en_o}, 32'd0);
    check("reset rdata", resp_rdata_o, 32'h0);
    check("reset mem addr|data", mem_addr_o | mem_data_o, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("ready after reset", {31'b0, req_ready_o}, 32'd1);

    // Table-driven single requests.
    for (int i = 0; i < 18; i++) begin
      run_req(vecs[i].name, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr,
              vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err);
    end
    check("mem word after rmw", mem[2], 32'hCAFE_AA44);

    // Back-to-back: valid held high across a word store and a load.
    @(negedge clk);
    rd_cnt      = 0;
    wr_cnt      = 0;
    req_valid_i = 1'b1;
    req_we_i    = 1'b1;
    req_size_i  = 2'b10;
    req_unsigned_i = 1'b0;
    req_addr_i  = 32'h0100_0010;
    req_wdata_i = 32'hA5A5_5A5A;
    @(posedge clk);
    @(negedge clk);
    req_we_i    = 1'b0;
    req_wdata_i = 32'h0;
    check("b2b ready in store", {31'b0, req_ready_o}, 32'd0);
    @(negedge clk);
    check("b2b resp/ready", {30'b0, resp_valid_o, req_ready_o}, 32'd2);
    @(negedge clk);
    check("b2b ready idle", {31'b0, req_ready_o}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    check("b2b load strobe", {31'b0, mem_read_en_o}, 32'd1);
    @(negedge clk);
    check("b2b resp", {31'b0, resp_valid_o}, 32'd1);
    check("b2b rdata", resp_rdata_o, 32'hA5A5_5A5A);
    check("b2b writes", wr_cnt, 1);

    // Reset during the RMW read cycle of a byte store.
    @(negedge clk);
    wr_cnt         = 0;
    req_valid_i    = 1'b1;
    req_we_i       = 1'b1;
    req_size_i     = 2'b00;
    req_addr_i     = 32'h0100_0008;
    req_wdata_i    = 32'h0000_0077;
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    check("rst rmw read", {31'b0, mem_read_en_o}, 32'd1);
    rst = 1'b0;
    #1;
    check("rst mid strobes", {27'b0, req_ready_o, resp_valid_o, resp_err_o, mem_read_en_o, mem_write_en_o}, 32'd0);
    check("rst mid addr|data|rdata", mem_addr_o | mem_data_o | resp_rdata_o, 32'h0);
    repeat (2) @(negedge clk);
    check("rst no write", wr_cnt, 0);
    check("rst mem unchanged", mem[2], 32'hCAFE_AA44);
    rst = 1'b1;
    @(negedge clk);
    check("rst ready after", {31'b0, req_ready_o}, 32'd1);
    run_req("lw after rst", 1'b0, 2'b10, 1'b0, 32'h0100_0008, 32'h0, 32'hCAFE_AA44, 1'b0);

    check("strobes exclusive", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
